// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, IF/ID outputs
// to the decoder, and hazard-unit controls.
//   master : fetch stage side (drives o_*, samples i_*)
//   slave  : environment side (memory, hazard unit, decoder)
// Signals:
//   i_stall          hold IF/ID contents and PC
//   i_flush          branch taken: redirect PC, squash IF/ID
//   i_branch_target  new PC, sampled when i_flush=1
//   o_imem_req       one-cycle request strobe
//   o_imem_addr      request address, valid while o_imem_req=1
//   i_imem_valid     one-cycle response strobe
//   i_imem_data      instruction, valid with i_imem_valid
//   o_instr          IF/ID instruction; [15:12] is the opcode
//   o_pc             PC of o_instr
//   o_valid          o_instr is a real instruction (0 = bubble)
interface fetch_stage_if #(
   parameter int PC_WIDTH    = 8,
   parameter int INSTR_WIDTH = 16
);
   logic                   i_stall;
   logic                   i_flush;
   logic [PC_WIDTH-1:0]    i_branch_target;
   logic                   o_imem_req;
   logic [PC_WIDTH-1:0]    o_imem_addr;
   logic                   i_imem_valid;
   logic [INSTR_WIDTH-1:0] i_imem_data;
   logic [INSTR_WIDTH-1:0] o_instr;
   logic [PC_WIDTH-1:0]    o_pc;
   logic                   o_valid;

   modport master (
      input  i_stall, i_flush, i_branch_target, i_imem_valid, i_imem_data,
      output o_imem_req, o_imem_addr, o_instr, o_pc, o_valid
   );

   modport slave (
      output i_stall, i_flush, i_branch_target, i_imem_valid, i_imem_data,
      input  o_imem_req, o_imem_addr, o_instr, o_pc, o_valid
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Holds the PC, issues single-outstanding reads to instruction memory and
// registers each returned instruction with its PC for the decoder. Honors
// hazard-unit stall (hold) and flush (redirect + bubble), and drops responses
// made stale by a redirect.
// Ports:
//   i_clk    clock, rising edge
//   i_reset  asynchronous active-high reset
//   bus      fetch_stage_if.master (memory bus, IF/ID outputs, stall/flush)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | one cycle after reset release, no request outstanding
// REQ     | o_imem_req high for this single cycle, address = pc
// WAIT    | request outstanding, waiting for i_imem_valid
// HOLD    | response parked in hold buffer while stalled; no requests
// DISCARD | outstanding response is stale (redirected); drop it on arrival
module fetch_stage #(
   parameter int                  PC_WIDTH    = 8,
   parameter int                  INSTR_WIDTH = 16,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
   input logic           i_clk,
   input logic           i_reset,
   fetch_stage_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_DISCARD
   } state_t;

   state_t                 state;
   logic [PC_WIDTH-1:0]    pc;
   logic [PC_WIDTH-1:0]    pc_inc;
   logic [PC_WIDTH-1:0]    hold_pc;
   logic [INSTR_WIDTH-1:0] hold_instr;
   logic                   hold_valid;

   // Wraps modulo 2^PC_WIDTH by truncation.
   assign pc_inc = pc + PC_WIDTH'(1);

   // o_imem_req defaults low every cycle and is raised only on the edge that
   // enters REQ, so the strobe is exactly one cycle wide and o_imem_addr is
   // loaded with the address being entered with.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state           <= S_IDLE;
         pc              <= RESET_PC;
         hold_pc         <= '0;
         hold_instr      <= '0;
         hold_valid      <= 1'b0;
         bus.o_imem_req  <= 1'b0;
         bus.o_imem_addr <= '0;
         bus.o_instr     <= '0;
         bus.o_pc        <= '0;
         bus.o_valid     <= 1'b0;
      end else begin
         bus.o_imem_req <= 1'b0;
         if (bus.i_flush) begin
            pc          <= bus.i_branch_target;
            bus.o_valid <= 1'b0;
            bus.o_instr <= '0;
            hold_valid  <= 1'b0;
            case (state)
               S_IDLE, S_HOLD: begin
                  state           <= S_REQ;
                  bus.o_imem_req  <= 1'b1;
                  bus.o_imem_addr <= bus.i_branch_target;
               end
               // Request already on the bus; its response is now stale.
               S_REQ: state <= S_DISCARD;
               // A response arriving with the flush is simply dropped; without
               // one, the outstanding response still has to be drained.
               S_WAIT, S_DISCARD: begin
                  if (bus.i_imem_valid) begin
                     state           <= S_REQ;
                     bus.o_imem_req  <= 1'b1;
                     bus.o_imem_addr <= bus.i_branch_target;
                  end else begin
                     state <= S_DISCARD;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end else begin
            // Unstalled cycles without a new instruction present a bubble;
            // stalled cycles leave IF/ID untouched.
            if (!bus.i_stall) begin
               bus.o_valid <= 1'b0;
            end
            case (state)
               S_IDLE: begin
                  state           <= S_REQ;
                  bus.o_imem_req  <= 1'b1;
                  bus.o_imem_addr <= pc;
               end
               S_REQ: state <= S_WAIT;
               S_WAIT: begin
                  if (bus.i_imem_valid) begin
                     pc <= pc_inc;
                     if (bus.i_stall) begin
                        hold_instr <= bus.i_imem_data;
                        hold_pc    <= pc;
                        hold_valid <= 1'b1;
                        state      <= S_HOLD;
                     end else begin
                        bus.o_instr     <= bus.i_imem_data;
                        bus.o_pc        <= pc;
                        bus.o_valid     <= 1'b1;
                        state           <= S_REQ;
                        bus.o_imem_req  <= 1'b1;
                        bus.o_imem_addr <= pc_inc;
                     end
                  end
               end
               S_HOLD: begin
                  if (!bus.i_stall) begin
                     bus.o_instr     <= hold_instr;
                     bus.o_pc        <= hold_pc;
                     bus.o_valid     <= hold_valid;
                     hold_valid      <= 1'b0;
                     state           <= S_REQ;
                     bus.o_imem_req  <= 1'b1;
                     bus.o_imem_addr <= pc;
                  end
               end
               S_DISCARD: begin
                  if (bus.i_imem_valid) begin
                     state           <= S_REQ;
                     bus.o_imem_req  <= 1'b1;
                     bus.o_imem_addr <= pc;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

   logic clk;
   logic rst;

   fetch_stage_if #(.PC_WIDTH(8), .INSTR_WIDTH(16)) bus ();

   fetch_stage #(
      .PC_WIDTH   (8),
      .INSTR_WIDTH(16),
      .RESET_PC   (8'h00)
   ) dut (
      .i_clk  (clk),
      .i_reset(rst),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Instruction memory model: response latency 'lat' cycles after the
   // request cycle; contents 16'h1000+addr except address 5.
   int         lat = 1;
   logic       mem_pend = 1'b0;
   int         mem_cnt = 0;
   logic [7:0] mem_addr = '0;

   function automatic logic [15:0] mem_word(input logic [7:0] a);
      if (a == 8'h05) return 16'h4123;
      return 16'h1000 + {8'h00, a};
   endfunction

   initial begin
      bus.i_imem_valid = 1'b0;
      bus.i_imem_data  = '0;
   end

   always @(negedge clk) begin
      bus.i_imem_valid = 1'b0;
      if (mem_pend) begin
         mem_cnt = mem_cnt - 1;
         if (mem_cnt == 0) begin
            bus.i_imem_valid = 1'b1;
            bus.i_imem_data  = mem_word(mem_addr);
            mem_pend         = 1'b0;
         end
      end
      if (bus.o_imem_req) begin
         mem_pend = 1'b1;
         mem_cnt  = lat;
         mem_addr = bus.o_imem_addr;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [15:0] instr,
                          input logic [7:0] pc, input logic valid);
      chk({tag, ".instr"}, 32'(bus.o_instr), 32'(instr));
      chk({tag, ".pc"},    32'(bus.o_pc),    32'(pc));
      chk({tag, ".valid"}, 32'(bus.o_valid), 32'(valid));
   endtask

   task automatic chk_req(input string tag, input logic req, input logic [7:0] addr);
      chk({tag, ".req"}, 32'(bus.o_imem_req), 32'(req));
      if (req) chk({tag, ".addr"}, 32'(bus.o_imem_addr), 32'(addr));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst                 = 1'b1;
      bus.i_stall         = 1'b0;
      bus.i_flush         = 1'b0;
      bus.i_branch_target = '0;

      tick(); tick();
      chk_out("reset", 16'h0000, 8'h00, 1'b0);
      chk("reset.req",  32'(bus.o_imem_req),  32'd0);
      chk("reset.addr", 32'(bus.o_imem_addr), 32'd0);
      rst = 1'b0;

      // Back-to-back fetch with 1-cycle memory.
      tick();                                   // P1
      chk_req("p1", 1'b1, 8'h00);
      tick();                                   // P2
      chk_req("p2", 1'b0, 8'h00);
      tick();                                   // P3
      chk_out("i0", 16'h1000, 8'h00, 1'b1);
      chk_req("i0", 1'b1, 8'h01);
      tick();                                   // P4
      chk("bubble.valid", 32'(bus.o_valid), 32'd0);
      chk_req("p4", 1'b0, 8'h00);
      tick();                                   // P5
      chk_out("i1", 16'h1001, 8'h01, 1'b1);
      chk_req("i1", 1'b1, 8'h02);
      tick(); tick();                           // P7
      chk_out("i2", 16'h1002, 8'h02, 1'b1);
      chk_req("i2", 1'b1, 8'h03);
      tick(); tick();                           // P9
      tick(); tick();                           // P11
      chk_out("i4", 16'h1004, 8'h04, 1'b1);
      chk_req("i4", 1'b1, 8'h05);

      // Stall while the pc=5 response arrives.
      tick();                                   // P12
      bus.i_stall = 1'b1;
      tick();                                   // P13
      chk_out("stall1", 16'h1004, 8'h04, 1'b0);
      chk_req("stall1", 1'b0, 8'h00);
      tick();                                   // P14
      chk_out("stall2", 16'h1004, 8'h04, 1'b0);
      chk_req("stall2", 1'b0, 8'h00);
      bus.i_stall = 1'b0;
      lat = 3;
      tick();                                   // P15
      chk_out("unhold", 16'h4123, 8'h05, 1'b1);
      chk_req("unhold", 1'b1, 8'h06);

      // Flush in WAIT with a 3-cycle response outstanding.
      tick();                                   // P16
      chk("p16.valid", 32'(bus.o_valid), 32'd0);
      bus.i_flush = 1'b1;
      bus.i_branch_target = 8'h40;
      tick();                                   // P17
      chk("flush.valid", 32'(bus.o_valid), 32'd0);
      chk("flush.instr", 32'(bus.o_instr), 32'd0);
      chk_req("flush", 1'b0, 8'h00);
      bus.i_flush = 1'b0;
      tick();                                   // P18
      chk_req("discard", 1'b0, 8'h00);
      tick();                                   // P19
      chk_req("redir", 1'b1, 8'h40);
      chk("redir.valid", 32'(bus.o_valid), 32'd0);
      lat = 1;
      tick(); tick();                           // P21
      chk_out("i40", 16'h1040, 8'h40, 1'b1);
      chk_req("i40", 1'b1, 8'h41);

      // Flush and stall together with a response: flush wins.
      tick();                                   // P22
      bus.i_stall = 1'b1;
      bus.i_flush = 1'b1;
      bus.i_branch_target = 8'h80;
      tick();                                   // P23
      chk("fs.valid", 32'(bus.o_valid), 32'd0);
      chk("fs.instr", 32'(bus.o_instr), 32'd0);
      chk_req("fs", 1'b1, 8'h80);
      bus.i_stall = 1'b0;
      bus.i_flush = 1'b0;
      tick(); tick();                           // P25
      chk_out("i80", 16'h1080, 8'h80, 1'b1);
      chk_req("i80", 1'b1, 8'h81);

      // Flush in REQ to 0xFF, then wrap to 0x00.
      bus.i_flush = 1'b1;
      bus.i_branch_target = 8'hFF;
      tick();                                   // P26
      chk_req("freq", 1'b0, 8'h00);
      chk("freq.valid", 32'(bus.o_valid), 32'd0);
      bus.i_flush = 1'b0;
      tick();                                   // P27
      chk_req("rff", 1'b1, 8'hFF);
      chk("rff.valid", 32'(bus.o_valid), 32'd0);
      tick(); tick();                           // P29
      chk_out("iff", 16'h10FF, 8'hFF, 1'b1);
      chk_req("wrap", 1'b1, 8'h00);
      tick(); tick();                           // P31
      chk_out("iwrap", 16'h1000, 8'h00, 1'b1);
      chk_req("iwrap", 1'b1, 8'h01);

      // Asynchronous reset mid-WAIT; the late response must be ignored.
      lat = 3;
      tick();                                   // P32
      #2;
      rst = 1'b1;
      #1;
      chk_out("areset", 16'h0000, 8'h00, 1'b0);
      chk("areset.req",  32'(bus.o_imem_req),  32'd0);
      chk("areset.addr", 32'(bus.o_imem_addr), 32'd0);
      tick();                                   // P33
      rst = 1'b0;
      lat = 1;
      tick();                                   // P34
      chk_req("restart", 1'b1, 8'h00);
      chk("restart.valid", 32'(bus.o_valid), 32'd0);
      tick();                                   // P35
      chk("stale.valid", 32'(bus.o_valid), 32'd0);
      chk_req("stale", 1'b0, 8'h00);
      tick();                                   // P36
      chk_out("r0", 16'h1000, 8'h00, 1'b1);
      chk_req("r0", 1'b1, 8'h01);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage and IF/ID pipeline register feeding the opcode decoder. Holds the PC and issues one-outstanding-request reads to instruction memory. Registers the returned instruction with its PC for decode; o_instr[15:12] is the decoder's 4-bit opcode. Applies hazard-unit stall (hold) and branch flush (redirect PC, insert bubble), and discards in-flight responses made stale by a redirect.

Parameters:
PC_WIDTH, 8, PC/instruction-address width (word addressed)
INSTR_WIDTH, 16, instruction width; opcode = bits [15:12]
RESET_PC, 0, PC value loaded on reset

Ports:
i_clk  input  1  clock, rising edge
i_reset  input  1  asynchronous, active-high reset
i_stall  input  1  hazard unit: hold IF/ID contents and PC
i_flush  input  1  hazard unit (branch taken): redirect PC, squash IF/ID
i_branch_target  input  PC_WIDTH  new PC, sampled when i_flush=1
o_imem_req  output  1  one-cycle request strobe
o_imem_addr  output  PC_WIDTH  request address, valid while o_imem_req=1
i_imem_valid  input  1  one-cycle response strobe, ≥1 cycle after req
i_imem_data  input  INSTR_WIDTH  instruction, valid with i_imem_valid
o_instr  output  INSTR_WIDTH  IF/ID instruction to decoder
o_pc  output  PC_WIDTH  PC of o_instr
o_valid  output  1  o_instr is a real instruction (0 = bubble)

Behaviour:
- Async reset: pc=RESET_PC, o_instr=0, o_pc=0, o_valid=0, o_imem_req=0, o_imem_addr=0, hold buffer empty, state=IDLE.
- States: IDLE, REQ, WAIT, HOLD, DISCARD.
- IDLE: one cycle after reset release -> REQ.
- REQ: o_imem_req=1, o_imem_addr=pc for exactly one cycle -> WAIT. If i_flush in REQ: pc<=target, -> DISCARD (request already issued).
- WAIT: on i_imem_valid and not stall/flush: o_instr<=data, o_pc<=pc, o_valid<=1, pc<=pc+1, -> REQ.
- WAIT, valid with i_stall=1 and i_flush=0: data/pc into 1-entry hold buffer, pc<=pc+1, -> HOLD; IF/ID unchanged.
- HOLD: when i_stall drops, buffer -> IF/ID (o_valid=1), -> REQ. No request issued while in HOLD.
- DISCARD: wait for i_imem_valid, drop data, -> REQ (fetch at redirected pc). If i_flush again, update pc; stay DISCARD.
- i_flush (any state) at edge: o_valid<=0, o_instr<=0, pc<=i_branch_target, hold buffer cleared. From WAIT without valid -> DISCARD. From WAIT with valid -> REQ (data dropped). From HOLD -> REQ. From IDLE -> REQ.
- Priority: reset > flush > stall > normal.
- i_stall with no new data: o_instr/o_pc/o_valid hold; fetch FSM continues until a response must be buffered.
- PC arithmetic: modulo 2^PC_WIDTH; 0xFF+1 = 0x00, no flag.
- Latency: req at cycle n, valid at n+k -> o_valid at n+k+1; next req at n+k+1.
- At most one outstanding request; o_imem_req never asserted in WAIT/HOLD/DISCARD.
- o_valid=0 cycles (bubbles) are the only output between accepted instructions when not stalled.

Test Plan:
- Reset then 1-cycle memory (mem[a]=16'h1000+a): req addr 0,1,2 every 2 cycles; o_instr 1000,1001,1002 with o_pc 0,1,2, o_valid=1.
- Assert i_stall while valid arrives (data 16'h4123 at pc 5): IF/ID unchanged, hold buffer loaded, no req; drop stall -> o_instr=4123, o_pc=5, next req addr 6.
- i_flush with target 0x40 while in WAIT (response 3-cycle latency): o_valid=0 next cycle; stale response dropped; next req addr 0x40; o_pc=0x40.
- Simultaneous i_flush and i_stall with valid: flush wins; o_valid=0, buffer empty, req addr = target.
- PC wrap: RESET_PC overridden/branch to 0xFF: fetch 0xFF then req addr 0x00.
- Assert i_reset mid-WAIT: outputs immediately 0, o_imem_req=0; late i_imem_valid ignored; fetch restarts at RESET_PC.
